// File: rtl/sram_cim_row_writer.sv
// rtl/sram_cim_row_writer.sv - packs input words into a row and commits it to the CIM SRAM macro
// Optional read-back check of the committed row is enabled by defining WRITE_VERIFY_EN.
module sram_cim_row_writer #(
    parameter int ROW_W     = 192,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NSEL      = 16,
    parameter int SETUP_CYC = 1,
    parameter int WRT_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [NSEL-1:0]   in_sel,
    input  logic              abort,
`ifdef WRITE_VERIFY_EN
    output logic              cim_rd,
    input  logic [ROW_W-1:0]  rd_q,
    output logic              verify_err,
`endif
    output logic [ADDR_W-1:0] cim_a,
    output logic [ROW_W-1:0]  cim_d,
    output logic [NSEL-1:0]   cim_sel,
    output logic              cim_reg_en,
    output logic              cim_col_en,
    output logic              cim_wrt,
    output logic              busy,
    output logic              done
);

    localparam int NWORDS = ROW_W / WORD_W;
    localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PC_MAX = (SETUP_CYC > WRT_CYC) ? SETUP_CYC : WRT_CYC;
    localparam int PC_W   = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;
    localparam logic [WC_W-1:0] LAST_WORD  = WC_W'(NWORDS - 1);
    localparam logic [PC_W-1:0] SETUP_LAST = PC_W'(SETUP_CYC - 1);
    localparam logic [PC_W-1:0] WRT_LAST   = PC_W'(WRT_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_VERIFY = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NSEL-1:0]   sel_q, sel_d;
    logic              done_q, done_d;
    logic              verr_q, verr_d;
    logic              accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pcnt_q  <= pcnt_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            verr_q  <= verr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pcnt_d  = pcnt_q;
        row_d   = row_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        verr_d  = verr_q;
        accept  = in_valid && !abort && (state_q == S_IDLE || state_q == S_FILL);
        // Abort leaves the row buffer and address untouched; only control state unwinds.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            wcnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    row_d[WORD_W-1:0] = in_data;
                    addr_d = in_addr;
                    sel_d  = in_sel;
                    verr_d = 1'b0;
                    if (NWORDS == 1) begin
                        state_d = S_SETUP;
                        pcnt_d  = '0;
                    end else begin
                        state_d = S_FILL;
                        wcnt_d  = WC_W'(1);
                    end
                end
                S_FILL: if (accept) begin
                    row_d[int'(wcnt_q)*WORD_W +: WORD_W] = in_data;
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = '0;
                        pcnt_d  = '0;
                        state_d = S_SETUP;
                    end else begin
                        wcnt_d = wcnt_q + WC_W'(1);
                    end
                end
                S_SETUP: if (pcnt_q == SETUP_LAST) begin
                    pcnt_d  = '0;
                    state_d = S_WRITE;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
                S_WRITE: if (pcnt_q == WRT_LAST) begin
                    pcnt_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
`ifdef WRITE_VERIFY_EN
                S_HOLD: begin
                    pcnt_d  = '0;
                    state_d = S_VERIFY;
                end
                S_VERIFY: if (pcnt_q == '0) begin
                    pcnt_d = PC_W'(1);
                end else begin
                    pcnt_d  = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (rd_q != row_q) verr_d = 1'b1;
                end
`else
                S_HOLD: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE) || (state_q == S_FILL);
        busy       = (state_q != S_IDLE);
        done       = done_q;
        cim_reg_en = (state_q == S_SETUP) || (state_q == S_WRITE) || (state_q == S_HOLD);
        cim_col_en = (state_q == S_WRITE);
        cim_wrt    = (state_q == S_WRITE);
        cim_a      = addr_q;
        cim_sel    = sel_q;
        // Inverted so that the inverting readout path returns the original words.
        cim_d      = ~row_q;
`ifdef WRITE_VERIFY_EN
        cim_rd     = (state_q == S_VERIFY) && (pcnt_q == '0);
        verify_err = verr_q;
`endif
    end

    logic unused_verr;
    assign unused_verr = verr_q;

endmodule

// File: tb/tb_sram_cim_row_writer.sv
// tb/tb_sram_cim_row_writer.sv - randomized bench for sram_cim_row_writer against a row/timeline model
module tb_sram_cim_row_writer;

    localparam int ROW_W = 192;
    localparam int WORD_W = 32;
    localparam int NW = ROW_W / WORD_W;
    localparam int SC = 1;
    localparam int WC = 2;
`ifdef WRITE_VERIFY_EN
    localparam int LAT = SC + WC + 4;
`else
    localparam int LAT = SC + WC + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic [7:0] in_addr = '0;
    logic [15:0] in_sel = '0;
    logic abort = 1'b0;
    logic [7:0] cim_a;
    logic [ROW_W-1:0] cim_d;
    logic [15:0] cim_sel;
    logic cim_reg_en, cim_col_en, cim_wrt, busy, done;
`ifdef WRITE_VERIFY_EN
    logic cim_rd, verify_err;
    logic [ROW_W-1:0] rd_q = '0;
`endif

    int n_checks = 0;
    int n_pass = 0;
    bit pending_done = 1'b0;

    always #5 clk = ~clk;

    sram_cim_row_writer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_sel(in_sel), .abort(abort),
`ifdef WRITE_VERIFY_EN
        .cim_rd(cim_rd), .rd_q(rd_q), .verify_err(verify_err),
`endif
        .cim_a(cim_a), .cim_d(cim_d), .cim_sel(cim_sel), .cim_reg_en(cim_reg_en),
        .cim_col_en(cim_col_en), .cim_wrt(cim_wrt), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Timeline after the last word is accepted: i=1 is the first cycle following that beat.
    function automatic logic [3:0] exp_strobe(input int i);
        if (i <= SC) return 4'b1000;
        if (i <= SC + WC) return 4'b1110;
        if (i == SC + WC + 1) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 normal, 1 abort at cycle kill_at, 2 reset at cycle kill_at
    task automatic write_row(input logic [7:0] addr, input logic [15:0] sel, input bit fixed,
                             input int stall_at, input int stall_len, input bit b2b,
                             input bit rd_flip, input int kind, input int kill_at);
        logic [ROW_W-1:0] row;
        logic [WORD_W-1:0] w;
        row = '0;
        for (int k = 0; k < NW; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    check("stall_ready", in_ready, 1);
                    check("stall_busy", busy, 1);
                    tick();
                end
            end
            w = fixed ? WORD_W'(k + 1) : $urandom;
            row[k*WORD_W +: WORD_W] = w;
            in_valid = 1'b1;
            in_data = w;
            in_addr = (k == 0) ? addr : 8'($urandom);
            in_sel = (k == 0) ? sel : 16'($urandom);
            @(negedge clk);
            check("in_ready", in_ready, 1);
            if (pending_done) begin
                check("done_b2b", {cim_reg_en, cim_col_en, cim_wrt, done}, 4'b0001);
                pending_done = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        in_addr = 8'($urandom);
        in_sel = 16'($urandom);
`ifdef WRITE_VERIFY_EN
        rd_q = rd_flip ? (row ^ (ROW_W'(1) << 100)) : row;
`endif
        for (int i = 1; i < LAT; i++) begin
            if (kind == 1 && i == kill_at) abort = 1'b1;
            if (kind == 2 && i == kill_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_wrt", {cim_reg_en, cim_col_en, cim_wrt, done}, 4'b0000);
                check("rst_cim_d", cim_d, {ROW_W{1'b1}});
                check("rst_ready", in_ready, 1);
                check("rst_busy", busy, 0);
                tick();
                rst_n = 1'b1;
                @(negedge clk);
                check("post_rst_ready", in_ready, 1);
                check("post_rst_cim_a", cim_a, 0);
                tick();
                return;
            end
            @(negedge clk);
            check($sformatf("strobe_c%0d", i), {cim_reg_en, cim_col_en, cim_wrt, done}, exp_strobe(i));
            check("busy_wr", busy, 1);
            check("ready_wr", in_ready, 0);
            if (i == 1) begin
                check("cim_d", cim_d, ~row);
                check("cim_a", cim_a, addr);
                check("cim_sel", cim_sel, sel);
`ifdef WRITE_VERIFY_EN
                check("verr_clear", verify_err, 0);
`endif
            end
`ifdef WRITE_VERIFY_EN
            check("cim_rd", cim_rd, (i == SC + WC + 2));
`endif
            tick();
            if (kind == 1 && i == kill_at) begin
                abort = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("abort_strobes", {cim_reg_en, cim_col_en, cim_wrt, done}, 4'b0000);
                    check("abort_busy", busy, 0);
                    check("abort_cim_d", cim_d, ~row);
                    tick();
                end
                return;
            end
        end
        if (b2b) begin
            pending_done = 1'b1;
        end else begin
            @(negedge clk);
            check("done", {cim_reg_en, cim_col_en, cim_wrt, done}, 4'b0001);
            check("done_busy", busy, 0);
            check("done_ready", in_ready, 1);
            check("done_cim_d", cim_d, ~row);
`ifdef WRITE_VERIFY_EN
            check("verify_err", verify_err, rd_flip);
`endif
            tick();
            @(negedge clk);
            check("done_pulse", done, 0);
`ifdef WRITE_VERIFY_EN
            check("verify_err_hold", verify_err, rd_flip);
`endif
            tick();
        end
    endtask

    initial begin
        #2;
        check("reset_ready", in_ready, 1);
        check("reset_strobes", {cim_reg_en, cim_col_en, cim_wrt, done, busy}, 5'b0);
        check("reset_cim_d", cim_d, {ROW_W{1'b1}});
        check("reset_cim_a", {cim_a, cim_sel}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        write_row(8'h3A, 16'h0004, 1'b1, -1, 0, 1'b0, 1'b0, 0, 0);
        write_row(8'h3A, 16'h0004, 1'b1, 3, 3, 1'b0, 1'b0, 0, 0);
        write_row(8'h11, 16'h0100, 1'b0, -1, 0, 1'b1, 1'b0, 0, 0);
        write_row(8'h22, 16'h0002, 1'b0, -1, 0, 1'b0, 1'b0, 0, 0);
        write_row(8'h3A, 16'h0004, 1'b1, -1, 0, 1'b0, 1'b0, 1, SC + 2);
        write_row(8'h5C, 16'h8000, 1'b0, -1, 0, 1'b0, 1'b0, 0, 0);

        abort = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("idle_abort_ready", in_ready, 1);
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_abort_noaccept", busy, 0);
        tick();

        write_row(8'h7E, 16'h0010, 1'b0, -1, 0, 1'b0, 1'b0, 2, SC + 1);
        write_row(8'h3A, 16'h0004, 1'b1, -1, 0, 1'b0, 1'b1, 0, 0);
        write_row(8'h01, 16'h0001, 1'b0, -1, 0, 1'b0, 1'b0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            bit b2b;
            int st;
            b2b = (r < 19) ? bit'($urandom_range(0, 1)) : 1'b0;
            st = $urandom_range(0, 2) == 0 ? -1 : $urandom_range(1, NW - 1);
            write_row(8'($urandom), 16'(1 << $urandom_range(0, 15)), 1'b0, st,
                      $urandom_range(1, 4), b2b, bit'($urandom_range(0, 1)), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=finish", n_checks);
        $fatal(1);
    end

endmodule
